pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Parametrised stall/flush controller for the in-order core pipeline; generalises the fixed 6-stage stall decoder.
- Accepts N stall-request sources, each mapped to a stage.
- Adds bubble generation and a flush path that survives a whole-pipeline stall.
- Sits beside the pipeline registers; drives their stall/bubble/flush inputs and the PC redirect.

Parameters:
- STAGE_NUM, 6, number of pipeline stages; index 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
- REQ_NUM, 3, number of stall-request sources.
- REQ_STAGE_MAP, 12'h432, packed 4-bit stage index per request; request i owns bits [4i+3:4i]. Default maps id = 2, ex = 3, mem = 4.
- ADDR_WIDTH, 32, flush target address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_all  in  1  freeze the whole pipeline (bus wait).
- stall_req  in  REQ_NUM  per-source stall request.
- flush_req  in  1  exception/redirect flush request, single-cycle pulse.
- flush_target  in  ADDR_WIDTH  redirect address, valid with flush_req.
- stall  out  STAGE_NUM  per-stage hold.
- bubble  out  STAGE_NUM  per-stage insert-NOP.
- flush  out  1  clear all stage registers, load PC.
- flush_pc  out  ADDR_WIDTH  PC redirect value, valid with flush.
- flush_pending  out  1  a flush is latched, waiting for stall_all to drop.

Behaviour:
- Reset (rst = 0, async): pend_valid = 0, pend_pc = 0. Outputs reflect only the combinational terms, with no pending flush.
- Flush output: flush = (flush_req | pend_valid) & ~stall_all.
  - flush_pc = pend_valid ? pend_pc : flush_target.
  - Combinational, so zero-cycle latency when not stalled.
- Pending latch:
  - Set: on a clock edge with flush_req & stall_all & ~pend_valid, set pend_valid and capture pend_pc <= flush_target.
  - Clear: cleared on the edge where flush = 1.
  - Oldest wins: flush_req while pend_valid is dropped, whether or not stall_all is high. A pending flush firing in the same cycle as a new flush_req outputs pend_pc; the new request is discarded.
  - flush_pending = pend_valid.
- Priority 1, stall_all = 1: stall = all ones, bubble = 0, flush = 0.
- Priority 2, flush = 1: stall = 0 and bubble = 0; stall_req is ignored.
- Priority 3, otherwise:
  - k = maximum mapped stage over asserted stall_req.
  - stall[j] = 1 for j <= k, else 0.
  - No request gives stall = 0.
- Bubble rule: bubble[0] = 0; bubble[j] = stall[j-1] & ~stall[j] for j >= 1 (the stage downstream of the stall boundary receives a NOP).
- Map rules:
  - Requests mapping to stage >= STAGE_NUM are ignored.
  - Several requests mapping to the same stage OR together.
- Reset mid-pending: the latched flush is lost; the bench must not expect it after reset.

Optional Feature:
- Macro: PIPELINE_HAZARD_PERF_EN.
- With the macro, two extra outputs:
  - stall_cycles (32 b): increments each cycle stall[0] = 1.
  - flush_count (32 b): increments each cycle flush = 1.
  - Both saturate at all ones and reset to 0.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include (bus.v style): stage index constants STAGE_PC..STAGE_WB, STAGE_NUM default, ADDR_WIDTH default.
- Sub-module: hazard_stall_decode, a combinational stall_req plus map to the stall vector (priority-max thermometer).
- The flush latch stays in the top.

Test Plan:
- stall_req = 3'b001 (id), stall_all = 0 -> stall = 6'b000111, bubble = 6'b001000, flush = 0.
- stall_req = 3'b101 (id + mem) -> stall = 6'b011111, bubble = 6'b100000.
- stall_all = 1 and stall_req = 3'b010 -> stall = 6'b111111, bubble = 0.
- flush_req with flush_target = 32'hBFC00380, stall_all = 0 -> same cycle: flush = 1, flush_pc = 32'hBFC00380, stall = 0; flush_pending stays 0.
- stall_all held 4 cycles; flush_req (target 32'h80000180) in cycle 1, second flush_req (target 32'h80000200) in cycle 3 -> flush_pending = 1 from cycle 2. First cycle with stall_all = 0: flush = 1, flush_pc = 32'h80000180. Next cycle: flush = 0, flush_pending = 0.
- Pending set, then rst pulsed low mid-cycle (async) -> flush_pending = 0 immediately; no flush after stall_all drops. With PIPELINE_HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - stage indices and default sizes shared by the hazard controller
package pipeline_hazard_controller_pkg;

    // Pipeline stage indices, front of the pipe first
    typedef enum logic [3:0] {
        STAGE_PC  = 4'd0,
        STAGE_IF  = 4'd1,
        STAGE_ID  = 4'd2,
        STAGE_EX  = 4'd3,
        STAGE_MEM = 4'd4,
        STAGE_WB  = 4'd5
    } stage_e;

    localparam int STAGE_NUM_DEF  = 6;
    localparam int ADDR_WIDTH_DEF = 32;

    // Thermometer mask with bits [0..stage] set; empty when stage is out of range
    function automatic logic [15:0] stage_therm(input logic [3:0] stage, input int num_stages);
        logic [15:0] m;
        m = '0;
        for (int j = 0; j < 16; j++) begin
            if ((j < num_stages) && (int'(stage) < num_stages) && (j <= int'(stage))) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_stall_decode.sv
// rtl/pipeline_hazard_controller_stall_decode.sv - stall requests to per-stage hold thermometer
module hazard_stall_decode
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int                   STAGE_NUM     = STAGE_NUM_DEF,
    parameter int                   REQ_NUM       = 3,
    parameter logic [4*REQ_NUM-1:0] REQ_STAGE_MAP = 12'h432
) (
    input  logic [REQ_NUM-1:0]   stall_req,
    output logic [STAGE_NUM-1:0] stall_vec
);

    // OR of per-request thermometers equals the thermometer of the deepest requested stage
    always_comb begin
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (stall_req[i]) begin
                acc = acc | stage_therm(REQ_STAGE_MAP[4*i +: 4], STAGE_NUM);
            end
        end
        stall_vec = acc[STAGE_NUM-1:0];
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/bubble/flush controller; optional PIPELINE_HAZARD_PERF_EN adds perf counters
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int                   STAGE_NUM     = STAGE_NUM_DEF,
    parameter int                   REQ_NUM       = 3,
    parameter logic [4*REQ_NUM-1:0] REQ_STAGE_MAP = 12'h432,
    parameter int                   ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_all,
    input  logic [REQ_NUM-1:0]    stall_req,
    input  logic                  flush_req,
    input  logic [ADDR_WIDTH-1:0] flush_target,
    output logic [STAGE_NUM-1:0]  stall,
    output logic [STAGE_NUM-1:0]  bubble,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  flush_pending
`ifdef PIPELINE_HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [STAGE_NUM-1:0]  req_stall;

    hazard_stall_decode #(
        .STAGE_NUM     (STAGE_NUM),
        .REQ_NUM       (REQ_NUM),
        .REQ_STAGE_MAP (REQ_STAGE_MAP)
    ) u_stall_decode (
        .stall_req (stall_req),
        .stall_vec (req_stall)
    );

    // Flush fires immediately unless frozen; a latched flush always beats a new request
    always_comb begin
        flush    = (flush_req | pend_valid_q) & ~stall_all;
        flush_pc = pend_valid_q ? pend_pc_q : flush_target;
    end

    // Stall priority: global freeze, then flush, then deepest stall request
    always_comb begin
        if (stall_all) begin
            stall = '1;
        end else if (flush) begin
            stall = '0;
        end else begin
            stall = req_stall;
        end
        bubble = '0;
        for (int j = 1; j < STAGE_NUM; j++) begin
            bubble[j] = stall[j-1] & ~stall[j];
        end
    end

    // Latch a flush that arrives during a freeze; drop any request while one is held
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        if (flush) begin
            pend_valid_d = 1'b0;
        end else if (flush_req && stall_all && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = flush_target;
        end
    end

    // Pending flush state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign flush_pending = pend_valid_q;

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
